hpi_responder: RTL and testbench
================================

# hpi_responder

Synthesizable responder for the four-register OTG host-port interface (HPI) that the Nios system drives through its `otg_hpi_*` PIO exports. It lets on-chip logic stand in for the USB controller chip on that bus, or act as a hardware-side endpoint for it. Host accesses land in an internal word RAM with an auto-incrementing address pointer, plus a bidirectional mailbox and a status register. A local-side port gives fabric logic (keycode and player-position decode) a RAM read path and mailbox access.

## Interface

Parameters:
- `MEM_AW`, default 8: RAM word-address width; depth is 2^MEM_AW × 16 bits.

Ports:
- `clk_clk`  in  1  system clock; everything below is synchronous to it.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `hpi_reset_n`  in  1  host soft reset (driven from `otg_hpi_reset_export`), active low, sampled synchronously.
- `hpi_cs_n`  in  1  chip select, active low.
- `hpi_r_n`  in  1  read strobe, active low.
- `hpi_w_n`  in  1  write strobe, active low.
- `hpi_address`  in  2  register select:
  - 0 = DATA
  - 1 = MAILBOX
  - 2 = ADDRESS
  - 3 = STATUS
- `hpi_data_in`  in  16  host write data.
- `hpi_data_out`  out  16  registered read data.
- `hpi_data_oe`  out  1  high while a read is active; the top level uses it to drive the tri-state bus.
- `mbx_rx_data`  out  16  last word the host wrote to MAILBOX.
- `mbx_rx_valid`  out  1  `mbx_rx_data` is unconsumed.
- `mbx_rx_ack`  in  1  one-cycle pulse; clears `mbx_rx_valid`.
- `mbx_tx_data`  in  16  word offered to the host.
- `mbx_tx_wr`  in  1  one-cycle pulse; loads `mbx_tx_data`.
- `mbx_tx_full`  out  1  tx mailbox holds a word the host has not yet read.
- `loc_addr`  in  MEM_AW  local RAM word address.
- `loc_rdata`  out  16  `mem[loc_addr]`, registered, latency 1.

## Operation

- **Input registering and edge detection.** `hpi_cs_n`, `hpi_r_n`, `hpi_w_n`, `hpi_address` and `hpi_data_in` are registered once (stage s1), then held one more stage (s2).
  - Write event: `cs_s1==0 && w_s1==0 && !(w_s2==0 && cs_s2==0)`.
  - Read event: the same form using the read strobe.
  - One access is performed per strobe assertion.
- **Simultaneous read and write events:** the write is performed and the read is ignored.
- **Write event by register:**
  - DATA: `mem[addr[MEM_AW:1]] <= data`; then `addr <= addr + 2`.
  - MAILBOX: `mbx_rx_data <= data`, `mbx_rx_valid <= 1`. If `mbx_rx_valid` was already 1, set sticky `ovr`.
  - ADDRESS: `addr <= data`, a 16-bit byte address; bit 0 is stored but ignored for indexing.
  - STATUS: no effect.
- **Read event by register** (result is loaded into `hpi_data_out`):
  - DATA: `mem[addr[MEM_AW:1]]`; then `addr <= addr + 2`.
  - MAILBOX: returns the tx word and clears `mbx_tx_full`.
  - ADDRESS: returns `addr`.
  - STATUS: returns `{13'b0, ovr, mbx_rx_valid, mbx_tx_full}`, then clears `ovr`.
- **Address arithmetic:** `addr` is 16 bits and wraps modulo 2^16 (0xFFFE + 2 = 0x0000). Addresses beyond the RAM depth alias through the truncated index.
- **Local mailbox side:**
  - `mbx_tx_wr` while `mbx_tx_full==1` is ignored; the held word is kept.
  - `mbx_tx_wr` on the same cycle as a host MAILBOX read event: the read returns the old word and clears full, then the new word loads and full ends at 1.
  - `mbx_rx_ack` on the same cycle as a host MAILBOX write: the write wins, so valid stays 1 and `ovr` is not set.
- **`hpi_data_oe`:** equals `cs_s1==0 && r_s1==0 && w_s1==1`.
- **Reset values** (applied both by `reset_reset_n` low, asynchronously, and by `hpi_reset_n` low, synchronously):
  - `addr` = 0
  - `hpi_data_out` = 0, `hpi_data_oe` = 0
  - `mbx_rx_data` = 0, `mbx_rx_valid` = 0
  - `mbx_tx_full` = 0, `ovr` = 0
  - `loc_rdata` = 0
  - Input stages = idle (all strobes 1).
  - RAM contents are not cleared.
  - An access in flight when reset asserts is discarded.
  - After reset releases, a strobe that is already low does not generate an event until it is deasserted and reasserted.

## Timing

- Strobe low at input before edge k: visible in s1 at edge k; the action commits at edge k+1.
  - Write data is in the RAM, and `addr` is incremented, after edge k+1.
  - Read data is valid on `hpi_data_out` after edge k+1, i.e. 2 cycles of latency.
- Host-side setup requirement: `hpi_address` and `hpi_data_in` must be stable from the strobe's falling edge for at least 2 cycles.
- `hpi_data_out` holds its value until the next read event or reset.
- `hpi_data_oe` rises 1 cycle after the read strobe asserts and falls 1 cycle after it deasserts.
- `mbx_rx_valid` and `mbx_tx_full` update at edge k+1 for host events, and at the edge after a local pulse.
- `loc_rdata` has 1-cycle latency. If a host write to the same word commits on the same edge, `loc_rdata` returns the old data.

## Test plan

- **RAM write/readback with auto-increment:** write ADDRESS=0x0010; write DATA 0xAAAA, 0xBBBB, 0xCCCC; write ADDRESS=0x0010; read DATA ×3 → 0xAAAA, 0xBBBB, 0xCCCC; read ADDRESS → 0x0016. `loc_addr`=9 → `loc_rdata`=0xBBBB one cycle later.
- **Mailbox both directions:**
  - Host writes MAILBOX 0x1234 → `mbx_rx_valid`=1, `mbx_rx_data`=0x1234; STATUS reads 0x0002; `mbx_rx_ack` → STATUS reads 0x0000.
  - `mbx_tx_wr` 0x5678 → STATUS reads 0x0001; MAILBOX reads 0x5678; `mbx_tx_full`=0.
- **Overrun and full boundaries:**
  - Two host MAILBOX writes without ack → STATUS reads 0x0006, then 0x0002 on the next read (`ovr` cleared).
  - Second `mbx_tx_wr` 0x9999 while full → host MAILBOX read returns the first word.
- **Simultaneous strobes and wrap-around:**
  - r and w asserted together on DATA at ADDRESS 0xFFFE → write happens, `hpi_data_oe` stays 0, ADDRESS reads 0x0000.
  - A write to 0x0200 with `MEM_AW`=8 aliases to word 0.
- **Reset mid-operation:**
  - Assert `hpi_reset_n` low during a held DATA write strobe → the write is discarded, ADDRESS reads 0, both mailbox flags are 0, and RAM is unchanged.
  - Repeat with `reset_reset_n` → outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hpi_responder.sv
// rtl/hpi_responder.sv - HPI bus responder: word RAM, auto-increment pointer, mailbox, status
//
// Purpose: stands in for the OTG controller on the four-register host-port
// interface. Host accesses hit a 2^MEM_AW x 16 RAM through a byte address
// pointer, a two-way mailbox and a status word. Fabric logic gets a RAM read
// port and the local side of the mailbox.
//
// Ports:
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   hpi_reset_n                 host soft reset, active low, synchronous
//   hpi_cs_n/r_n/w_n            host strobes, active low
//   hpi_address[1:0]            0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   hpi_data_in/out, hpi_data_oe host data bus halves and output enable
//   mbx_rx_data/valid/ack       host-to-fabric mailbox
//   mbx_tx_data/wr/full         fabric-to-host mailbox
//   loc_addr, loc_rdata         local RAM read, latency 1
module hpi_responder #(
   parameter int MEM_AW = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              hpi_reset_n,
   input  logic              hpi_cs_n,
   input  logic              hpi_r_n,
   input  logic              hpi_w_n,
   input  logic [1:0]        hpi_address,
   input  logic [15:0]       hpi_data_in,
   output logic [15:0]       hpi_data_out,
   output logic              hpi_data_oe,
   output logic [15:0]       mbx_rx_data,
   output logic              mbx_rx_valid,
   input  logic              mbx_rx_ack,
   input  logic [15:0]       mbx_tx_data,
   input  logic              mbx_tx_wr,
   output logic              mbx_tx_full,
   input  logic [MEM_AW-1:0] loc_addr,
   output logic [15:0]       loc_rdata
);

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_MBX  = 2'd1;
   localparam logic [1:0] REG_ADDR = 2'd2;
   localparam logic [1:0] REG_STAT = 2'd3;

   logic [15:0] mem [2**MEM_AW];

   logic              cs_s1_q, cs_s1_d, r_s1_q, r_s1_d, w_s1_q, w_s1_d;
   logic [1:0]        a_s1_q, a_s1_d;
   logic [15:0]       d_s1_q, d_s1_d;
   logic              cs_s2_q, cs_s2_d, r_s2_q, r_s2_d, w_s2_q, w_s2_d;
   logic              w_arm_q, w_arm_d, r_arm_q, r_arm_d;
   logic [15:0]       addr_q, addr_d;
   logic [15:0]       dout_q, dout_d;
   logic [15:0]       rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic [15:0]       tx_data_q, tx_data_d;
   logic              tx_full_q, tx_full_d;
   logic              ovr_q, ovr_d;
   logic [15:0]       loc_rdata_q, loc_rdata_d;

   logic              w_act_s1, w_act_s2, r_act_s1, r_act_s2;
   logic              wr_ev, rd_ev, mem_we;
   logic [MEM_AW-1:0] mem_idx;

   assign w_act_s1 = !cs_s1_q && !w_s1_q;
   assign w_act_s2 = !cs_s2_q && !w_s2_q;
   assign r_act_s1 = !cs_s1_q && !r_s1_q;
   assign r_act_s2 = !cs_s2_q && !r_s2_q;

   // The arm flags only set once the raw strobe has been seen inactive, so a
   // strobe still held low across reset release cannot produce an event.
   assign wr_ev   = w_act_s1 && !w_act_s2 && w_arm_q;
   assign rd_ev   = r_act_s1 && !r_act_s2 && r_arm_q && !wr_ev;
   assign mem_idx = addr_q[MEM_AW:1];

   always_comb begin
      cs_s1_d     = hpi_cs_n;
      r_s1_d      = hpi_r_n;
      w_s1_d      = hpi_w_n;
      a_s1_d      = hpi_address;
      d_s1_d      = hpi_data_in;
      cs_s2_d     = cs_s1_q;
      r_s2_d      = r_s1_q;
      w_s2_d      = w_s1_q;
      w_arm_d     = w_arm_q | hpi_cs_n | hpi_w_n;
      r_arm_d     = r_arm_q | hpi_cs_n | hpi_r_n;
      addr_d      = addr_q;
      dout_d      = dout_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      tx_data_d   = tx_data_q;
      tx_full_d   = tx_full_q;
      ovr_d       = ovr_q;
      mem_we      = 1'b0;
      loc_rdata_d = mem[loc_addr];

      if (mbx_rx_ack) rx_valid_d = 1'b0;

      if (wr_ev) begin
         case (a_s1_q)
            REG_DATA: begin
               mem_we = 1'b1;
               addr_d = addr_q + 16'd2;
            end
            REG_MBX: begin
               rx_data_d  = d_s1_q;
               rx_valid_d = 1'b1;
               // A same-cycle ack consumed the old word, so it is not lost.
               if (rx_valid_q && !mbx_rx_ack) ovr_d = 1'b1;
            end
            REG_ADDR: addr_d = d_s1_q;
            default: ;
         endcase
      end else if (rd_ev) begin
         case (a_s1_q)
            REG_DATA: begin
               dout_d = mem[mem_idx];
               addr_d = addr_q + 16'd2;
            end
            REG_MBX: begin
               dout_d    = tx_data_q;
               tx_full_d = 1'b0;
            end
            REG_ADDR: dout_d = addr_q;
            REG_STAT: begin
               dout_d = {13'b0, ovr_q, rx_valid_q, tx_full_q};
               ovr_d  = 1'b0;
            end
            default: ;
         endcase
      end

      // Evaluated after the host read so a same-cycle MAILBOX read frees the slot.
      if (mbx_tx_wr && !tx_full_d) begin
         tx_data_d = mbx_tx_data;
         tx_full_d = 1'b1;
      end

      if (!hpi_reset_n) begin
         cs_s1_d     = 1'b1;
         r_s1_d      = 1'b1;
         w_s1_d      = 1'b1;
         a_s1_d      = 2'd0;
         d_s1_d      = 16'd0;
         cs_s2_d     = 1'b1;
         r_s2_d      = 1'b1;
         w_s2_d      = 1'b1;
         w_arm_d     = 1'b0;
         r_arm_d     = 1'b0;
         addr_d      = 16'd0;
         dout_d      = 16'd0;
         rx_data_d   = 16'd0;
         rx_valid_d  = 1'b0;
         tx_data_d   = 16'd0;
         tx_full_d   = 1'b0;
         ovr_d       = 1'b0;
         mem_we      = 1'b0;
         loc_rdata_d = 16'd0;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cs_s1_q     <= 1'b1;
         r_s1_q      <= 1'b1;
         w_s1_q      <= 1'b1;
         a_s1_q      <= 2'd0;
         d_s1_q      <= 16'd0;
         cs_s2_q     <= 1'b1;
         r_s2_q      <= 1'b1;
         w_s2_q      <= 1'b1;
         w_arm_q     <= 1'b0;
         r_arm_q     <= 1'b0;
         addr_q      <= 16'd0;
         dout_q      <= 16'd0;
         rx_data_q   <= 16'd0;
         rx_valid_q  <= 1'b0;
         tx_data_q   <= 16'd0;
         tx_full_q   <= 1'b0;
         ovr_q       <= 1'b0;
         loc_rdata_q <= 16'd0;
      end else begin
         cs_s1_q     <= cs_s1_d;
         r_s1_q      <= r_s1_d;
         w_s1_q      <= w_s1_d;
         a_s1_q      <= a_s1_d;
         d_s1_q      <= d_s1_d;
         cs_s2_q     <= cs_s2_d;
         r_s2_q      <= r_s2_d;
         w_s2_q      <= w_s2_d;
         w_arm_q     <= w_arm_d;
         r_arm_q     <= r_arm_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_data_q   <= tx_data_d;
         tx_full_q   <= tx_full_d;
         ovr_q       <= ovr_d;
         loc_rdata_q <= loc_rdata_d;
      end
   end

   // RAM has no reset; contents survive both resets.
   always_ff @(posedge clk_clk) begin
      if (mem_we) mem[mem_idx] <= d_s1_q;
   end

   assign hpi_data_out = dout_q;
   assign hpi_data_oe  = !cs_s1_q && !r_s1_q && w_s1_q;
   assign mbx_rx_data  = rx_data_q;
   assign mbx_rx_valid = rx_valid_q;
   assign mbx_tx_full  = tx_full_q;
   assign loc_rdata    = loc_rdata_q;

endmodule

// File: tb/tb_hpi_responder.sv
// tb/tb_hpi_responder.sv - scoreboard bench for hpi_responder
module tb_hpi_responder;

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_MBX  = 2'd1;
   localparam logic [1:0] A_ADDR = 2'd2;
   localparam logic [1:0] A_STAT = 2'd3;

   logic        clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic        hpi_reset_n = 1'b1;
   logic        hpi_cs_n = 1'b1, hpi_r_n = 1'b1, hpi_w_n = 1'b1;
   logic [1:0]  hpi_address = 2'd0;
   logic [15:0] hpi_data_in = 16'd0;
   logic [15:0] hpi_data_out;
   logic        hpi_data_oe;
   logic [15:0] mbx_rx_data;
   logic        mbx_rx_valid;
   logic        mbx_rx_ack = 1'b0;
   logic [15:0] mbx_tx_data = 16'd0;
   logic        mbx_tx_wr = 1'b0;
   logic        mbx_tx_full;
   logic [7:0]  loc_addr = 8'd0;
   logic [15:0] loc_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } exp_t;
   exp_t sb_q[$];
   logic prev_oe = 1'b0;

   always #5 clk = ~clk;

   hpi_responder #(.MEM_AW(8)) dut (
      .clk_clk      (clk),
      .reset_reset_n(reset_reset_n),
      .hpi_reset_n  (hpi_reset_n),
      .hpi_cs_n     (hpi_cs_n),
      .hpi_r_n      (hpi_r_n),
      .hpi_w_n      (hpi_w_n),
      .hpi_address  (hpi_address),
      .hpi_data_in  (hpi_data_in),
      .hpi_data_out (hpi_data_out),
      .hpi_data_oe  (hpi_data_oe),
      .mbx_rx_data  (mbx_rx_data),
      .mbx_rx_valid (mbx_rx_valid),
      .mbx_rx_ack   (mbx_rx_ack),
      .mbx_tx_data  (mbx_tx_data),
      .mbx_tx_wr    (mbx_tx_wr),
      .mbx_tx_full  (mbx_tx_full),
      .loc_addr     (loc_addr),
      .loc_rdata    (loc_rdata)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   // A host read is complete when the output enable drops; the data is held.
   always @(negedge clk) begin
      if (prev_oe && !hpi_data_oe) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_read: got 0x%04h expected no read", hpi_data_out);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, hpi_data_out, e.exp);
         end
      end
      prev_oe <= hpi_data_oe;
   end

   task automatic host_write(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      hpi_address = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
      repeat (3) @(negedge clk);
      hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic host_read(input logic [1:0] a, input logic [15:0] exp, input string name);
      sb_q.push_back('{name: name, exp: exp});
      @(negedge clk);
      hpi_address = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
      repeat (3) @(negedge clk);
      hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic tx_write(input logic [15:0] d);
      @(negedge clk);
      mbx_tx_data = d; mbx_tx_wr = 1'b1;
      @(negedge clk);
      mbx_tx_wr = 1'b0;
   endtask

   task automatic rx_ack();
      @(negedge clk);
      mbx_rx_ack = 1'b1;
      @(negedge clk);
      mbx_rx_ack = 1'b0;
   endtask

   task automatic loc_check(input logic [7:0] a, input logic [15:0] exp, input string name);
      @(negedge clk);
      loc_addr = a;
      @(negedge clk);
      check(name, loc_rdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst_dout", hpi_data_out, 16'h0000);
      check("rst_oe", hpi_data_oe, 16'h0);
      check("rst_rx_data", mbx_rx_data, 16'h0000);
      check("rst_rx_valid", mbx_rx_valid, 16'h0);
      check("rst_tx_full", mbx_tx_full, 16'h0);
      check("rst_loc_rdata", loc_rdata, 16'h0000);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // RAM write/readback with auto-increment
      host_write(A_ADDR, 16'h0010);
      host_write(A_DATA, 16'hAAAA);
      host_write(A_DATA, 16'hBBBB);
      host_write(A_DATA, 16'hCCCC);
      host_write(A_ADDR, 16'h0010);
      host_read(A_DATA, 16'hAAAA, "ram_rd0");
      host_read(A_DATA, 16'hBBBB, "ram_rd1");
      host_read(A_DATA, 16'hCCCC, "ram_rd2");
      host_read(A_ADDR, 16'h0016, "addr_after_incr");
      loc_check(8'd9, 16'hBBBB, "loc_rd_word9");

      // mailbox, host to fabric
      host_write(A_MBX, 16'h1234);
      check("rx_valid_set", mbx_rx_valid, 16'h1);
      check("rx_data", mbx_rx_data, 16'h1234);
      host_read(A_STAT, 16'h0002, "stat_rx_valid");
      rx_ack();
      check("rx_valid_acked", mbx_rx_valid, 16'h0);
      host_read(A_STAT, 16'h0000, "stat_after_ack");

      // mailbox, fabric to host
      tx_write(16'h5678);
      check("tx_full_set", mbx_tx_full, 16'h1);
      host_read(A_STAT, 16'h0001, "stat_tx_full");
      host_read(A_MBX, 16'h5678, "mbx_rd");
      check("tx_full_clr", mbx_tx_full, 16'h0);

      // overrun is sticky until a STATUS read
      host_write(A_MBX, 16'h1111);
      host_write(A_MBX, 16'h2222);
      check("rx_data_overrun", mbx_rx_data, 16'h2222);
      host_read(A_STAT, 16'h0006, "stat_ovr");
      host_read(A_STAT, 16'h0002, "stat_ovr_cleared");
      rx_ack();

      // second local write while full is dropped
      tx_write(16'hAAA1);
      tx_write(16'h9999);
      host_read(A_MBX, 16'hAAA1, "mbx_rd_first_word");
      check("tx_full_after_rd", mbx_tx_full, 16'h0);

      // simultaneous strobes at the top of the address space
      host_write(A_ADDR, 16'hFFFE);
      @(negedge clk);
      hpi_address = A_DATA; hpi_data_in = 16'h4321;
      hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
      repeat (2) @(negedge clk);
      check("oe_rw_together", hpi_data_oe, 16'h0);
      @(negedge clk);
      hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
      repeat (2) @(negedge clk);
      host_read(A_ADDR, 16'h0000, "addr_wrap");
      loc_check(8'd255, 16'h4321, "loc_rd_word255");

      // aliasing beyond the RAM depth
      host_write(A_ADDR, 16'h0200);
      host_write(A_DATA, 16'h5A5A);
      loc_check(8'd0, 16'h5A5A, "alias_word0");
      host_read(A_ADDR, 16'h0202, "addr_after_alias");

      // soft reset during a held write strobe
      host_write(A_ADDR, 16'h0010);
      host_write(A_MBX, 16'h7777);
      tx_write(16'h3333);
      @(negedge clk);
      hpi_address = A_DATA; hpi_data_in = 16'hDEAD;
      hpi_cs_n = 1'b0; hpi_w_n = 1'b0; hpi_reset_n = 1'b0;
      repeat (2) @(negedge clk);
      hpi_reset_n = 1'b1;
      repeat (3) @(negedge clk);
      hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
      repeat (2) @(negedge clk);
      check("soft_rx_valid", mbx_rx_valid, 16'h0);
      check("soft_tx_full", mbx_tx_full, 16'h0);
      check("soft_rx_data", mbx_rx_data, 16'h0000);
      host_read(A_ADDR, 16'h0000, "soft_addr");
      host_read(A_STAT, 16'h0000, "soft_stat");
      loc_check(8'd8, 16'hAAAA, "soft_ram_word8");
      host_read(A_DATA, 16'h5A5A, "soft_ram_word0");

      // asynchronous reset during a held write strobe
      host_write(A_MBX, 16'h8888);
      tx_write(16'h4444);
      host_read(A_STAT, 16'h0003, "pre_async_stat");
      loc_check(8'd9, 16'hBBBB, "pre_async_loc");
      @(negedge clk);
      hpi_address = A_DATA; hpi_data_in = 16'hBEEF;
      hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
      #2 reset_reset_n = 1'b0;
      #1;
      check("async_dout", hpi_data_out, 16'h0000);
      check("async_oe", hpi_data_oe, 16'h0);
      check("async_rx_data", mbx_rx_data, 16'h0000);
      check("async_rx_valid", mbx_rx_valid, 16'h0);
      check("async_tx_full", mbx_tx_full, 16'h0);
      check("async_loc_rdata", loc_rdata, 16'h0000);
      repeat (2) @(negedge clk);
      reset_reset_n = 1'b1;
      repeat (3) @(negedge clk);
      hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
      repeat (2) @(negedge clk);
      host_read(A_ADDR, 16'h0000, "async_addr");
      host_read(A_DATA, 16'h5A5A, "async_ram_word0");

      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      check("sb_drained", 16'(sb_q.size()), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
